// File: rtl/multisim_client_axi_push.sv
// multisim_client_axi_push: client-side AXI subordinate bridging AW/W/AR/B/R to multisim transport streams.
module multisim_client_axi_push_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_d,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_d,
    output logic         out_vld,
    input  logic         out_rdy
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   cnt;
    logic         push, pop;

    // ready/valid come only from occupancy, never from the opposite side's handshake
    assign in_rdy  = !rst && cnt != 2'd2;
    assign out_vld = !rst && cnt != 2'd0;
    assign out_d   = mem[rp];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_d;
endmodule

module multisim_client_axi_push #(
    parameter type axi_aw_t = logic [31:0],
    parameter type axi_w_t  = logic [31:0],
    parameter type axi_b_t  = logic [1:0],
    parameter type axi_ar_t = logic [31:0],
    parameter type axi_r_t  = logic [32:0],
    parameter int  MAX_OUTSTANDING = 8,
    parameter int  R_LAST_BIT = 0,
    parameter int  CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$bits(axi_aw_t)-1:0] i_axi_s_aw,
    input  logic                       i_axi_s_awvalid,
    output logic                       o_axi_s_awready,
    input  logic [$bits(axi_w_t)-1:0]  i_axi_s_w,
    input  logic                       i_axi_s_wvalid,
    output logic                       o_axi_s_wready,
    output logic [$bits(axi_b_t)-1:0]  o_axi_s_b,
    output logic                       o_axi_s_bvalid,
    input  logic                       i_axi_s_bready,
    input  logic [$bits(axi_ar_t)-1:0] i_axi_s_ar,
    input  logic                       i_axi_s_arvalid,
    output logic                       o_axi_s_arready,
    output logic [$bits(axi_r_t)-1:0]  o_axi_s_r,
    output logic                       o_axi_s_rvalid,
    input  logic                       i_axi_s_rready,
    output logic [$bits(axi_aw_t)-1:0] o_tx_aw,
    output logic                       o_tx_aw_vld,
    input  logic                       i_tx_aw_rdy,
    output logic [$bits(axi_w_t)-1:0]  o_tx_w,
    output logic                       o_tx_w_vld,
    input  logic                       i_tx_w_rdy,
    output logic [$bits(axi_ar_t)-1:0] o_tx_ar,
    output logic                       o_tx_ar_vld,
    input  logic                       i_tx_ar_rdy,
    input  logic [$bits(axi_b_t)-1:0]  i_rx_b,
    input  logic                       i_rx_b_vld,
    output logic                       o_rx_b_rdy,
    input  logic [$bits(axi_r_t)-1:0]  i_rx_r,
    input  logic                       i_rx_r_vld,
    output logic                       o_rx_r_rdy,
    output logic [CW-1:0]              o_wr_outstanding,
    output logic [CW-1:0]              o_rd_outstanding,
    output logic                       o_err_unexp_b,
    output logic                       o_err_unexp_r
);
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic          aw_buf_rdy, ar_buf_rdy, wr_room, rd_room;
    logic          aw_hs, ar_hs, b_dec, r_dec, rx_b_hs, rx_r_hs;

    assign wr_room         = wr_cnt < CW'(MAX_OUTSTANDING);
    assign rd_room         = rd_cnt < CW'(MAX_OUTSTANDING);
    assign o_axi_s_awready = aw_buf_rdy && wr_room;
    assign o_axi_s_arready = ar_buf_rdy && rd_room;
    assign aw_hs           = i_axi_s_awvalid && o_axi_s_awready;
    assign ar_hs           = i_axi_s_arvalid && o_axi_s_arready;
    // saturate at zero: responses arriving with nothing outstanding never wrap the count
    assign b_dec           = o_axi_s_bvalid && i_axi_s_bready && wr_cnt != '0;
    assign r_dec           = o_axi_s_rvalid && i_axi_s_rready && o_axi_s_r[R_LAST_BIT] && rd_cnt != '0;
    assign rx_b_hs         = i_rx_b_vld && o_rx_b_rdy;
    assign rx_r_hs         = i_rx_r_vld && o_rx_r_rdy;
    assign o_wr_outstanding = wr_cnt;
    assign o_rd_outstanding = rd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            o_err_unexp_b <= 1'b0;
            o_err_unexp_r <= 1'b0;
        end else begin
            wr_cnt        <= wr_cnt + CW'(aw_hs) - CW'(b_dec);
            rd_cnt        <= rd_cnt + CW'(ar_hs) - CW'(r_dec);
            o_err_unexp_b <= o_err_unexp_b | (rx_b_hs && wr_cnt == '0);
            o_err_unexp_r <= o_err_unexp_r | (rx_r_hs && rd_cnt == '0);
        end
    end

    multisim_client_axi_push_skid #(.W($bits(axi_aw_t))) u_aw (
        .clk(clk), .rst(rst), .in_d(i_axi_s_aw), .in_vld(i_axi_s_awvalid && wr_room), .in_rdy(aw_buf_rdy),
        .out_d(o_tx_aw), .out_vld(o_tx_aw_vld), .out_rdy(i_tx_aw_rdy));
    multisim_client_axi_push_skid #(.W($bits(axi_w_t))) u_w (
        .clk(clk), .rst(rst), .in_d(i_axi_s_w), .in_vld(i_axi_s_wvalid), .in_rdy(o_axi_s_wready),
        .out_d(o_tx_w), .out_vld(o_tx_w_vld), .out_rdy(i_tx_w_rdy));
    multisim_client_axi_push_skid #(.W($bits(axi_ar_t))) u_ar (
        .clk(clk), .rst(rst), .in_d(i_axi_s_ar), .in_vld(i_axi_s_arvalid && rd_room), .in_rdy(ar_buf_rdy),
        .out_d(o_tx_ar), .out_vld(o_tx_ar_vld), .out_rdy(i_tx_ar_rdy));
    multisim_client_axi_push_skid #(.W($bits(axi_b_t))) u_b (
        .clk(clk), .rst(rst), .in_d(i_rx_b), .in_vld(i_rx_b_vld), .in_rdy(o_rx_b_rdy),
        .out_d(o_axi_s_b), .out_vld(o_axi_s_bvalid), .out_rdy(i_axi_s_bready));
    multisim_client_axi_push_skid #(.W($bits(axi_r_t))) u_r (
        .clk(clk), .rst(rst), .in_d(i_rx_r), .in_vld(i_rx_r_vld), .in_rdy(o_rx_r_rdy),
        .out_d(o_axi_s_r), .out_vld(o_axi_s_rvalid), .out_rdy(i_axi_s_rready));
endmodule

// File: tb/tb_multisim_client_axi_push.sv
// tb_multisim_client_axi_push: directed self-checking bench, MAX_OUTSTANDING=4, last flag in r[0].
module tb_multisim_client_axi_push;
    typedef logic [15:0] aw_t;
    typedef logic [7:0]  w_t;
    typedef logic [1:0]  b_t;
    typedef logic [15:0] ar_t;
    typedef logic [8:0]  r_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] i_axi_s_aw = '0, i_axi_s_ar = '0, o_tx_aw, o_tx_ar;
    logic [7:0]  i_axi_s_w = '0, o_tx_w;
    logic [1:0]  o_axi_s_b, i_rx_b = '0;
    logic [8:0]  o_axi_s_r, i_rx_r = '0;
    logic i_axi_s_awvalid = 0, o_axi_s_awready, i_axi_s_wvalid = 0, o_axi_s_wready;
    logic o_axi_s_bvalid, i_axi_s_bready = 1, i_axi_s_arvalid = 0, o_axi_s_arready;
    logic o_axi_s_rvalid, i_axi_s_rready = 1;
    logic o_tx_aw_vld, i_tx_aw_rdy = 1, o_tx_w_vld, i_tx_w_rdy = 1, o_tx_ar_vld, i_tx_ar_rdy = 1;
    logic i_rx_b_vld = 0, o_rx_b_rdy, i_rx_r_vld = 0, o_rx_r_rdy;
    logic [2:0] o_wr_outstanding, o_rd_outstanding;
    logic o_err_unexp_b, o_err_unexp_r;
    int checks = 0, errors = 0;

    multisim_client_axi_push #(
        .axi_aw_t(aw_t), .axi_w_t(w_t), .axi_b_t(b_t), .axi_ar_t(ar_t), .axi_r_t(r_t),
        .MAX_OUTSTANDING(4), .R_LAST_BIT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .i_axi_s_aw(i_axi_s_aw), .i_axi_s_awvalid(i_axi_s_awvalid), .o_axi_s_awready(o_axi_s_awready),
        .i_axi_s_w(i_axi_s_w), .i_axi_s_wvalid(i_axi_s_wvalid), .o_axi_s_wready(o_axi_s_wready),
        .o_axi_s_b(o_axi_s_b), .o_axi_s_bvalid(o_axi_s_bvalid), .i_axi_s_bready(i_axi_s_bready),
        .i_axi_s_ar(i_axi_s_ar), .i_axi_s_arvalid(i_axi_s_arvalid), .o_axi_s_arready(o_axi_s_arready),
        .o_axi_s_r(o_axi_s_r), .o_axi_s_rvalid(o_axi_s_rvalid), .i_axi_s_rready(i_axi_s_rready),
        .o_tx_aw(o_tx_aw), .o_tx_aw_vld(o_tx_aw_vld), .i_tx_aw_rdy(i_tx_aw_rdy),
        .o_tx_w(o_tx_w), .o_tx_w_vld(o_tx_w_vld), .i_tx_w_rdy(i_tx_w_rdy),
        .o_tx_ar(o_tx_ar), .o_tx_ar_vld(o_tx_ar_vld), .i_tx_ar_rdy(i_tx_ar_rdy),
        .i_rx_b(i_rx_b), .i_rx_b_vld(i_rx_b_vld), .o_rx_b_rdy(o_rx_b_rdy),
        .i_rx_r(i_rx_r), .i_rx_r_vld(i_rx_r_vld), .o_rx_r_rdy(o_rx_r_rdy),
        .o_wr_outstanding(o_wr_outstanding), .o_rd_outstanding(o_rd_outstanding),
        .o_err_unexp_b(o_err_unexp_b), .o_err_unexp_r(o_err_unexp_r)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        {i_axi_s_awvalid, i_axi_s_wvalid, i_axi_s_arvalid, i_rx_b_vld, i_rx_r_vld} = '0;
        {i_axi_s_bready, i_axi_s_rready, i_tx_aw_rdy, i_tx_w_rdy, i_tx_ar_rdy} = '1;
        tick;
        tick;
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        logic [11:0] v;
        rst = 1;
        {i_axi_s_awvalid, i_axi_s_wvalid, i_axi_s_arvalid, i_rx_b_vld, i_rx_r_vld} = '1;
        repeat (3) tick;
        v = {o_axi_s_awready, o_axi_s_wready, o_axi_s_arready, o_rx_b_rdy, o_rx_r_rdy, o_tx_aw_vld,
             o_tx_w_vld, o_tx_ar_vld, o_axi_s_bvalid, o_axi_s_rvalid, o_err_unexp_b, o_err_unexp_r};
        checks++;
        if (v !== 12'h000) begin errors++; $display("FAIL reset_hs got=%h exp=000", v); end
        checks++;
        if ({o_wr_outstanding, o_rd_outstanding} !== 6'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_wr_outstanding, o_rd_outstanding);
        end
        rst = 0;
        {i_axi_s_wvalid, i_axi_s_arvalid, i_rx_b_vld, i_rx_r_vld} = '0;
        i_axi_s_aw = 16'h1234;
        #1;
        checks++;
        if (o_axi_s_awready !== 1'b1) begin errors++; $display("FAIL reset_first_awready got=%b exp=1", o_axi_s_awready); end
        tick;
        i_axi_s_awvalid = 0;
        checks++;
        if ({o_tx_aw_vld, o_tx_aw, o_wr_outstanding} !== {1'b1, 16'h1234, 3'd1}) begin
            errors++; $display("FAIL reset_first_aw got=%b/%h/%0d exp=1/1234/1", o_tx_aw_vld, o_tx_aw, o_wr_outstanding);
        end
    endtask

    task automatic test_single_write;
        do_reset;
        i_axi_s_aw = 16'h1000; i_axi_s_awvalid = 1;
        i_axi_s_w = 8'hA5; i_axi_s_wvalid = 1;
        tick;
        i_axi_s_awvalid = 0; i_axi_s_wvalid = 0;
        checks++;
        if ({o_tx_aw_vld, o_tx_aw, o_tx_w_vld, o_tx_w, o_wr_outstanding} !== {1'b1, 16'h1000, 1'b1, 8'hA5, 3'd1}) begin
            errors++; $display("FAIL wr_fwd got=%b/%h/%b/%h/%0d exp=1/1000/1/a5/1",
                               o_tx_aw_vld, o_tx_aw, o_tx_w_vld, o_tx_w, o_wr_outstanding);
        end
        tick;
        checks++;
        if ({o_tx_aw_vld, o_tx_w_vld} !== 2'b00) begin errors++; $display("FAIL wr_drain got=%b%b exp=00", o_tx_aw_vld, o_tx_w_vld); end
        i_rx_b = 2'b00; i_rx_b_vld = 1;
        tick;
        i_rx_b_vld = 0;
        checks++;
        if ({o_axi_s_bvalid, o_axi_s_b, o_wr_outstanding} !== {1'b1, 2'b00, 3'd1}) begin
            errors++; $display("FAIL wr_b got=%b/%b/%0d exp=1/00/1", o_axi_s_bvalid, o_axi_s_b, o_wr_outstanding);
        end
        tick;
        checks++;
        if ({o_axi_s_bvalid, o_wr_outstanding, o_err_unexp_b} !== {1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL wr_done got=%b/%0d/%b exp=0/0/0", o_axi_s_bvalid, o_wr_outstanding, o_err_unexp_b);
        end
    endtask

    task automatic test_outstanding_limit;
        int acc;
        do_reset;
        acc = 0;
        i_axi_s_ar = 16'h2000; i_axi_s_arvalid = 1;
        for (int i = 0; i < 6; i++) begin
            if (o_axi_s_arready) acc++;
            tick;
        end
        i_axi_s_arvalid = 0;
        checks++;
        if (acc !== 4) begin errors++; $display("FAIL lim_accepted got=%0d exp=4", acc); end
        checks++;
        if ({o_axi_s_arready, o_rd_outstanding} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL lim_full got=%b/%0d exp=0/4", o_axi_s_arready, o_rd_outstanding);
        end
        i_rx_r = {8'h11, 1'b0}; i_rx_r_vld = 1;
        tick;
        checks++;
        if ({o_axi_s_rvalid, o_axi_s_r} !== {1'b1, 9'h022}) begin
            errors++; $display("FAIL lim_r1 got=%b/%h exp=1/022", o_axi_s_rvalid, o_axi_s_r);
        end
        i_rx_r = {8'h22, 1'b1};
        tick;
        i_rx_r_vld = 0;
        checks++;
        if ({o_axi_s_rvalid, o_axi_s_r, o_rd_outstanding} !== {1'b1, 9'h045, 3'd4}) begin
            errors++; $display("FAIL lim_r2 got=%b/%h/%0d exp=1/045/4", o_axi_s_rvalid, o_axi_s_r, o_rd_outstanding);
        end
        tick;
        checks++;
        if ({o_rd_outstanding, o_axi_s_arready} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL lim_release got=%0d/%b exp=3/1", o_rd_outstanding, o_axi_s_arready);
        end
        i_axi_s_arvalid = 1;
        tick;
        i_axi_s_arvalid = 0;
        checks++;
        if ({o_rd_outstanding, o_axi_s_arready} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL lim_refill got=%0d/%b exp=4/0", o_rd_outstanding, o_axi_s_arready);
        end
    endtask

    task automatic test_backpressure;
        int nsent, nrecv;
        logic hs_in, hs_out, wr_b;
        do_reset;
        nsent = 0; nrecv = 0;
        i_axi_s_w = 8'h30; i_axi_s_wvalid = 1;
        for (int c = 0; c < 200 && nrecv < 16; c++) begin
            wr_b = o_axi_s_wready;
            i_tx_w_rdy = (c % 4 == 0) || (c % 4 == 3);
            #1;
            checks++;
            if (o_axi_s_wready !== wr_b) begin errors++; $display("FAIL bp_comb c=%0d got=%b exp=%b", c, o_axi_s_wready, wr_b); end
            hs_in = i_axi_s_wvalid && o_axi_s_wready;
            hs_out = o_tx_w_vld && i_tx_w_rdy;
            if (hs_out) begin
                checks++;
                if (o_tx_w !== 8'(8'h30 + nrecv)) begin
                    errors++; $display("FAIL bp_data n=%0d got=%h exp=%h", nrecv, o_tx_w, 8'(8'h30 + nrecv));
                end
                nrecv++;
            end
            tick;
            if (hs_in) nsent++;
            i_axi_s_wvalid = nsent < 16;
            i_axi_s_w = 8'(8'h30 + nsent);
        end
        i_tx_w_rdy = 1;
        checks++;
        if (nrecv !== 16 || nsent !== 16) begin errors++; $display("FAIL bp_count got=%0d/%0d exp=16/16", nsent, nrecv); end
        checks++;
        if (o_tx_w_vld !== 1'b0) begin errors++; $display("FAIL bp_extra got=%b exp=0", o_tx_w_vld); end
    endtask

    task automatic test_unexpected;
        do_reset;
        i_rx_b = 2'b10; i_rx_b_vld = 1;
        tick;
        i_rx_b_vld = 0;
        checks++;
        if ({o_err_unexp_b, o_axi_s_bvalid, o_axi_s_b, o_wr_outstanding} !== {1'b1, 1'b1, 2'b10, 3'd0}) begin
            errors++; $display("FAIL unexp_b got=%b/%b/%b/%0d exp=1/1/10/0", o_err_unexp_b, o_axi_s_bvalid, o_axi_s_b, o_wr_outstanding);
        end
        repeat (3) tick;
        checks++;
        if ({o_err_unexp_b, o_axi_s_bvalid, o_wr_outstanding, o_err_unexp_r} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++; $display("FAIL unexp_sticky got=%b/%b/%0d/%b exp=1/0/0/0",
                               o_err_unexp_b, o_axi_s_bvalid, o_wr_outstanding, o_err_unexp_r);
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        i_axi_s_awvalid = 1;
        tick;
        tick;
        i_axi_s_awvalid = 0;
        i_axi_s_bready = 0;
        i_rx_b = 2'b00; i_rx_b_vld = 1;
        tick;
        i_rx_b_vld = 0;
        checks++;
        if ({o_axi_s_bvalid, o_wr_outstanding} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL sim_pre got=%b/%0d exp=1/2", o_axi_s_bvalid, o_wr_outstanding);
        end
        i_axi_s_awvalid = 1; i_axi_s_bready = 1;
        tick;
        i_axi_s_awvalid = 0;
        checks++;
        if ({o_wr_outstanding, o_axi_s_bvalid} !== {3'd2, 1'b0}) begin
            errors++; $display("FAIL sim_same got=%0d/%b exp=2/0", o_wr_outstanding, o_axi_s_bvalid);
        end
        i_tx_aw_rdy = 0; i_axi_s_awvalid = 1;
        i_axi_s_rready = 0; i_rx_r = 9'h1FF; i_rx_r_vld = 1;
        tick;
        i_axi_s_awvalid = 0; i_rx_r_vld = 0;
        checks++;
        if ({o_err_unexp_r, o_axi_s_rvalid, o_tx_aw_vld, o_wr_outstanding} !== {1'b1, 1'b1, 1'b1, 3'd3}) begin
            errors++; $display("FAIL sim_midburst got=%b/%b/%b/%0d exp=1/1/1/3",
                               o_err_unexp_r, o_axi_s_rvalid, o_tx_aw_vld, o_wr_outstanding);
        end
        rst = 1;
        tick;
        rst = 0;
        #1;
        checks++;
        if ({o_err_unexp_r, o_axi_s_rvalid, o_tx_aw_vld, o_wr_outstanding, o_rd_outstanding} !== 9'd0) begin
            errors++; $display("FAIL sim_rst got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0",
                               o_err_unexp_r, o_axi_s_rvalid, o_tx_aw_vld, o_wr_outstanding, o_rd_outstanding);
        end
        i_tx_aw_rdy = 1; i_axi_s_rready = 1;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_outstanding_limit;
        test_backpressure;
        test_unexpected;
        test_simultaneous;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
